// File: rtl/lag_window_param.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : lag_window_param
// Purpose  : Lag-windows r[1..ORDER] in memory using G.729 Mpy_32/L_Extract.
//            Define LAG_WINDOW_SAT_FLAG_EN to add the sticky satFlag output.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
module lag_window_param #(
  parameter int ORDER  = 10,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] srcBase,
  input  logic [ADDR_W-1:0] dstBase,
  output logic [ADDR_W-1:0] memReadAddr,
  input  logic [31:0]       memIn,
  output logic [ADDR_W-1:0] coefAddr,
  input  logic [31:0]       coefIn,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memWriteAddr,
  output logic [31:0]       memOut,
  output logic              busy,
  output logic              done
`ifdef LAG_WINDOW_SAT_FLAG_EN
  ,
  output logic              satFlag
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WT   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4,
    WR   = 3'd5,
    FIN  = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] C_ORDER = ADDR_W'(ORDER);
  localparam logic [ADDR_W-1:0] C_ONE   = ADDR_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_mem;
  logic [31:0]       r_coef;
  logic [31:0]       r_acc;
  logic [31:0]       w_prod;
  logic [31:0]       w_sum1;
  logic [31:0]       w_sum2;
  logic [15:0]       w_cross1;
  logic [15:0]       w_cross2;
  logic              w_prodOv;
  logic              w_cross1Ov;
  logic              w_cross2Ov;
  logic              w_sum1Ov;
  logic              w_sum2Ov;
  logic              w_unusedBits;

  // L_mult: doubled 16x16 product; only -1.0 * -1.0 overflows
  function automatic logic [32:0] lMult(input logic signed [15:0] a, input logic signed [15:0] b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    if (p == 32'sh4000_0000) lMult = {1'b1, 32'h7FFF_FFFF};
    else                     lMult = {1'b0, p[30:0], 1'b0};
  endfunction

  function automatic logic [16:0] mult16(input logic signed [15:0] a, input logic signed [15:0] b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    if (p == 32'sh4000_0000) mult16 = {1'b1, 16'h7FFF};
    else                     mult16 = {1'b0, p[30:15]};
  endfunction

  function automatic logic [32:0] lAdd(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) lAdd = {1'b1, (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    else                lAdd = {1'b0, s[31:0]};
  endfunction

  always_comb begin
    {w_prodOv, w_prod}     = lMult(r_mem[31:16], r_coef[31:16]);
    {w_cross1Ov, w_cross1} = mult16(r_mem[31:16], r_coef[15:0]);
    {w_cross2Ov, w_cross2} = mult16(r_mem[15:0], r_coef[31:16]);
    {w_sum1Ov, w_sum1}     = lAdd(r_acc, {{15{w_cross1[15]}}, w_cross1, 1'b0});
    {w_sum2Ov, w_sum2}     = lAdd(w_sum1, {{15{w_cross2[15]}}, w_cross2, 1'b0});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = RD;
      end
      RD:      w_next = WT;
      WT:      w_next = M1;
      M1:      w_next = M2;
      M2:      w_next = WR;
      WR:      w_next = (r_idx < C_ORDER) ? RD : FIN;
      FIN: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef LAG_WINDOW_SAT_FLAG_EN
  logic r_sat;
  assign satFlag      = r_sat;
  assign w_unusedBits = w_sum2[0];
`else
  assign w_unusedBits = ^{w_sum2[0], w_prodOv, w_cross1Ov, w_cross2Ov, w_sum1Ov, w_sum2Ov};
`endif

  // Addresses are loaded on entry to RD so they are valid throughout RD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src        <= '0;
      r_dst        <= '0;
      r_idx        <= '0;
      r_mem        <= '0;
      r_coef       <= '0;
      r_acc        <= '0;
      memReadAddr  <= '0;
      coefAddr     <= '0;
      memWrite     <= 1'b0;
      memWriteAddr <= '0;
      memOut       <= '0;
`ifdef LAG_WINDOW_SAT_FLAG_EN
      r_sat        <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_src       <= srcBase;
          r_dst       <= dstBase;
          r_idx       <= C_ONE;
          memReadAddr <= srcBase + C_ONE;
          coefAddr    <= '0;
`ifdef LAG_WINDOW_SAT_FLAG_EN
          r_sat       <= 1'b0;
`endif
        end
        WT: begin
          r_mem  <= memIn;
          r_coef <= coefIn;
        end
        M1: begin
          r_acc <= w_prod;
`ifdef LAG_WINDOW_SAT_FLAG_EN
          if (w_prodOv) r_sat <= 1'b1;
`endif
        end
        M2: begin
          memWrite     <= 1'b1;
          memWriteAddr <= r_dst + r_idx;
          // L_Extract: lo = (L>>1) - (hi<<15) reduces to L[15:1]
          memOut       <= {w_sum2[31:16], 1'b0, w_sum2[15:1]};
`ifdef LAG_WINDOW_SAT_FLAG_EN
          if (w_cross1Ov || w_cross2Ov || w_sum1Ov || w_sum2Ov) r_sat <= 1'b1;
`endif
        end
        WR: begin
          memWrite <= 1'b0;
          if (r_idx < C_ORDER) begin
            r_idx       <= r_idx + C_ONE;
            memReadAddr <= r_src + r_idx + C_ONE;
            coefAddr    <= r_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lag_window_param.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : tb_lag_window_param
// Purpose  : Self-checking bench for lag_window_param against a G.729 model.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
module tb_lag_window_param;
  localparam int ORDER  = 10;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LAT    = 5 * ORDER + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] srcBase = '0;
  logic [ADDR_W-1:0] dstBase = '0;
  logic [31:0]       memIn = '0;
  logic [31:0]       coefIn = '0;
  logic [ADDR_W-1:0] memReadAddr, coefAddr, memWriteAddr;
  logic [31:0]       memOut;
  logic              memWrite, busy, done;
`ifdef LAG_WINDOW_SAT_FLAG_EN
  logic              satFlag;
  bit                vecSat [3] = '{1'b0, 1'b1, 1'b0};
`endif

  int  nCmp = 0;
  int  nFail = 0;
  int  doneCnt = 0;
  bit  modelOvf = 1'b0;
  bit  expSat = 1'b0;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       coefTab [DEPTH];
  logic [ADDR_W-1:0] rdAddrD = '0;
  logic [ADDR_W-1:0] coefAddrD = '0;
  logic [ADDR_W-1:0] wrAddrQ[$], expAddrQ[$];
  logic [31:0]       wrDataQ[$], expDataQ[$];
  logic [31:0]       vecMem  [3] = '{32'h4000_0000, 32'h8000_0000, 32'h1234_5678};
  logic [31:0]       vecCoef [3] = '{32'h7FFF_0000, 32'h8000_0000, 32'h7FFF_7FFF};
  logic [31:0]       vecOut  [3] = '{32'h3FFF_4000, 32'h7FFF_7FFF, 32'h1234_5676};

  lag_window_param #(.ORDER(ORDER), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .srcBase(srcBase), .dstBase(dstBase),
    .memReadAddr(memReadAddr), .memIn(memIn), .coefAddr(coefAddr), .coefIn(coefIn),
    .memWrite(memWrite), .memWriteAddr(memWriteAddr), .memOut(memOut),
    .busy(busy), .done(done)
`ifdef LAG_WINDOW_SAT_FLAG_EN
    , .satFlag(satFlag)
`endif
  );

  always #5 clk = ~clk;

  // Reference arithmetic: exact integers, then clamp to the target width
  function automatic longint sat(input longint v, input int bits);
    longint hi, lo;
    hi = (longint'(1) << (bits - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) begin modelOvf = 1'b1; return hi; end
    if (v < lo) begin modelOvf = 1'b1; return lo; end
    return v;
  endfunction

  function automatic logic [31:0] refCoef(input logic [31:0] r, input logic [31:0] lag);
    longint rh, rl, lh, ll, acc, hi, lo;
    rh  = longint'($signed(r[31:16]));
    rl  = longint'($signed(r[15:0]));
    lh  = longint'($signed(lag[31:16]));
    ll  = longint'($signed(lag[15:0]));
    acc = sat(2 * rh * lh, 32);
    acc = sat(acc + 2 * sat((rh * ll) >>> 15, 16), 32);
    acc = sat(acc + 2 * sat((rl * lh) >>> 15, 16), 32);
    hi  = acc >>> 16;
    lo  = (acc >>> 1) - hi * 32768;
    return {hi[15:0], lo[15:0]};
  endfunction

  // One clock of the environment: synchronous memories with one-cycle read latency
  task automatic step();
    @(negedge clk);
    memIn     = mem[rdAddrD];
    coefIn    = coefTab[coefAddrD];
    rdAddrD   = memReadAddr;
    coefAddrD = coefAddr;
    if (memWrite === 1'b1) begin
      wrAddrQ.push_back(memWriteAddr);
      wrDataQ.push_back(memOut);
      mem[memWriteAddr] = memOut;
    end
    if (done === 1'b1) doneCnt++;
  endtask

  task automatic buildExpected(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d);
    logic [31:0] em [DEPTH];
    em = mem;
    expAddrQ.delete(); expDataQ.delete(); wrAddrQ.delete(); wrDataQ.delete();
    doneCnt  = 0;
    modelOvf = 1'b0;
    for (int i = 1; i <= ORDER; i++) begin
      logic [ADDR_W-1:0] ra, wa;
      logic [31:0] w;
      ra = s + ADDR_W'(i);
      wa = d + ADDR_W'(i);
      w  = refCoef(em[ra], coefTab[i-1]);
      em[wa] = w;
      expAddrQ.push_back(wa);
      expDataQ.push_back(w);
    end
    expSat = modelOvf;
  endtask

  // Start is sampled at the edge that opens cycle 1 of the run
  task automatic launch(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d);
    buildExpected(s, d);
    srcBase = s;
    dstBase = d;
    start   = 1'b1;
    step();
    start   = 1'b0;
    srcBase = ADDR_W'($urandom);
    dstBase = ADDR_W'($urandom);
  endtask

  task automatic waitDone(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < LAT + 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic fillRandom();
    for (int a = 0; a < DEPTH; a++) begin
      case ($urandom_range(0, 7))
        0:       mem[a] = 32'h8000_0000;
        1:       mem[a] = 32'h7FFF_FFFF;
        default: mem[a] = $urandom;
      endcase
      coefTab[a] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    repeat (3) step();
    nCmp++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b want 0", busy); end
    nCmp++; if (done !== 1'b0) begin nFail++; $display("FAIL reset_done: got %b want 0", done); end
    nCmp++; if (memWrite !== 1'b0) begin nFail++; $display("FAIL reset_memWrite: got %b want 0", memWrite); end
    nCmp++; if ({memReadAddr, coefAddr, memWriteAddr} !== '0) begin
      nFail++; $display("FAIL reset_addrs: got %h/%h/%h want 0", memReadAddr, coefAddr, memWriteAddr);
    end
    nCmp++; if (memOut !== 32'h0) begin nFail++; $display("FAIL reset_memOut: got %h want 0", memOut); end
`ifdef LAG_WINDOW_SAT_FLAG_EN
    nCmp++; if (satFlag !== 1'b0) begin nFail++; $display("FAIL reset_satFlag: got %b want 0", satFlag); end
`endif
    reset = 1'b1;
    repeat (2) step();
    nCmp++; if (busy !== 1'b0) begin nFail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_directed();
    int cyc;
    for (int v = 0; v < 3; v++) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a]     = vecMem[v];
        coefTab[a] = vecCoef[v];
      end
      launch(11'h100, 11'h200);
      waitDone(cyc);
      nCmp++; if (cyc !== LAT) begin nFail++; $display("FAIL vec%0d_latency: got %0d want %0d", v, cyc, LAT); end
`ifdef LAG_WINDOW_SAT_FLAG_EN
      nCmp++; if (satFlag !== vecSat[v]) begin nFail++; $display("FAIL vec%0d_satFlag: got %b want %b", v, satFlag, vecSat[v]); end
`endif
      repeat (3) step();
      nCmp++; if (wrAddrQ.size() !== ORDER) begin nFail++; $display("FAIL vec%0d_count: got %0d want %0d", v, wrAddrQ.size(), ORDER); end
      for (int k = 0; k < wrAddrQ.size(); k++) begin
        nCmp++;
        if (wrAddrQ[k] !== ADDR_W'(11'h200 + k + 1) || wrDataQ[k] !== vecOut[v]) begin
          nFail++; $display("FAIL vec%0d_write%0d: got %h@%h want %h@%h", v, k, wrDataQ[k], wrAddrQ[k], vecOut[v], ADDR_W'(11'h200 + k + 1));
        end
      end
      nCmp++; if (doneCnt !== 1) begin nFail++; $display("FAIL vec%0d_doneCount: got %0d want 1", v, doneCnt); end
    end
  endtask

  task automatic test_wrap_inplace();
    int cyc;
    fillRandom();
    launch(11'h7FE, 11'h7FE);
    waitDone(cyc);
    repeat (2) step();
    nCmp++; if (cyc !== LAT) begin nFail++; $display("FAIL wrap_latency: got %0d want %0d", cyc, LAT); end
    nCmp++; if (wrAddrQ.size() !== ORDER) begin nFail++; $display("FAIL wrap_count: got %0d want %0d", wrAddrQ.size(), ORDER); end
    for (int k = 0; k < wrAddrQ.size() && k < ORDER; k++) begin
      logic [ADDR_W-1:0] ea;
      ea = (k == 0) ? 11'h7FF : ADDR_W'(k - 1);
      nCmp++;
      if (wrAddrQ[k] !== ea || wrDataQ[k] !== expDataQ[k]) begin
        nFail++; $display("FAIL wrap_write%0d: got %h@%h want %h@%h", k, wrDataQ[k], wrAddrQ[k], expDataQ[k], ea);
      end
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int r = 0; r < 4; r++) begin
      fillRandom();
      launch(ADDR_W'($urandom), ADDR_W'($urandom));
      waitDone(cyc);
      nCmp++; if (cyc !== LAT) begin nFail++; $display("FAIL rand%0d_latency: got %0d want %0d", r, cyc, LAT); end
`ifdef LAG_WINDOW_SAT_FLAG_EN
      nCmp++; if (satFlag !== expSat) begin nFail++; $display("FAIL rand%0d_satFlag: got %b want %b", r, satFlag, expSat); end
`endif
      repeat (2) step();
      nCmp++; if (wrAddrQ.size() !== ORDER) begin nFail++; $display("FAIL rand%0d_count: got %0d want %0d", r, wrAddrQ.size(), ORDER); end
      for (int k = 0; k < wrAddrQ.size() && k < ORDER; k++) begin
        nCmp++;
        if (wrAddrQ[k] !== expAddrQ[k] || wrDataQ[k] !== expDataQ[k]) begin
          nFail++; $display("FAIL rand%0d_write%0d: got %h@%h want %h@%h", r, k, wrDataQ[k], wrAddrQ[k], expDataQ[k], expAddrQ[k]);
        end
      end
      nCmp++; if (doneCnt !== 1) begin nFail++; $display("FAIL rand%0d_doneCount: got %0d want 1", r, doneCnt); end
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    fillRandom();
    launch(11'h040, 11'h300);
    cyc = 1;
    while (done !== 1'b1 && cyc < LAT + 100) begin
      if (cyc == 3 || cyc == 30) begin
        start = 1'b1; srcBase = 11'h500; dstBase = 11'h600;
      end else begin
        start = 1'b0;
      end
      if (cyc == 30) begin
        nCmp++; if (busy !== 1'b1) begin nFail++; $display("FAIL ignore_busy: got %b want 1", busy); end
      end
      step();
      cyc++;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (60) step();
    nCmp++; if (cyc !== LAT) begin nFail++; $display("FAIL ignore_latency: got %0d want %0d", cyc, LAT); end
    nCmp++; if (wrAddrQ.size() !== ORDER) begin nFail++; $display("FAIL ignore_count: got %0d want %0d", wrAddrQ.size(), ORDER); end
    nCmp++; if (doneCnt !== 1) begin nFail++; $display("FAIL ignore_doneCount: got %0d want 1", doneCnt); end
    nCmp++; if (busy !== 1'b0) begin nFail++; $display("FAIL ignore_idle: got %b want 0", busy); end
    for (int k = 0; k < wrAddrQ.size() && k < ORDER; k++) begin
      nCmp++;
      if (wrAddrQ[k] !== expAddrQ[k] || wrDataQ[k] !== expDataQ[k]) begin
        nFail++; $display("FAIL ignore_write%0d: got %h@%h want %h@%h", k, wrDataQ[k], wrAddrQ[k], expDataQ[k], expAddrQ[k]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    fillRandom();
    launch(11'h010, 11'h400);
    for (cyc = 1; cyc < 12; cyc++) step();
    reset = 1'b0;
    #1;
    nCmp++; if (busy !== 1'b0 || memWrite !== 1'b0 || done !== 1'b0) begin
      nFail++; $display("FAIL midrun_outputs: got busy=%b wr=%b done=%b want 0/0/0", busy, memWrite, done);
    end
    nCmp++; if (memReadAddr !== '0 || memOut !== '0) begin
      nFail++; $display("FAIL midrun_clear: got %h/%h want 0/0", memReadAddr, memOut);
    end
    repeat (3) step();
    reset = 1'b1;
    repeat (20) step();
    nCmp++; if (wrAddrQ.size() !== 2 || doneCnt !== 0) begin
      nFail++; $display("FAIL midrun_abandon: got %0d writes %0d done want 2/0", wrAddrQ.size(), doneCnt);
    end
    nCmp++; if (mem[11'h401] !== expDataQ[0] || mem[11'h402] !== expDataQ[1]) begin
      nFail++; $display("FAIL midrun_kept: got %h %h want %h %h", mem[11'h401], mem[11'h402], expDataQ[0], expDataQ[1]);
    end
    launch(11'h020, 11'h500);
    cyc = 1;
    while (memWrite !== 1'b1 && cyc < 20) begin step(); cyc++; end
    reset = 1'b0;
    #1;
    nCmp++; if (memWrite !== 1'b0 || cyc >= 20) begin
      nFail++; $display("FAIL wr_reset: got memWrite=%b at cycle %0d want 0 before 20", memWrite, cyc);
    end
    step();
    reset = 1'b1;
    step();
    launch(11'h030, 11'h600);
    waitDone(cyc);
    repeat (2) step();
    nCmp++; if (cyc !== LAT) begin nFail++; $display("FAIL rerun_latency: got %0d want %0d", cyc, LAT); end
    nCmp++; if (wrAddrQ.size() !== ORDER || doneCnt !== 1) begin
      nFail++; $display("FAIL rerun_count: got %0d writes %0d done want %0d/1", wrAddrQ.size(), doneCnt, ORDER);
    end
    for (int k = 0; k < wrAddrQ.size() && k < ORDER; k++) begin
      nCmp++;
      if (wrAddrQ[k] !== expAddrQ[k] || wrDataQ[k] !== expDataQ[k]) begin
        nFail++; $display("FAIL rerun_write%0d: got %h@%h want %h@%h", k, wrDataQ[k], wrAddrQ[k], expDataQ[k], expAddrQ[k]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      mem[a]     = '0;
      coefTab[a] = '0;
    end
    test_reset();
    test_directed();
    test_wrap_inplace();
    test_random();
    test_start_ignored();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lag_window_param.md
LAG_WINDOW_PARAM -- requirements
Module: lag_window_param

Interface
REQ-001 SHALL: ORDER, default 10, number of lag-windowed coefficients r[1..ORDER].
REQ-002 SHALL: ADDR_W, default 11, width of memory and coefficient addresses.
REQ-003 SHALL: clk  input  1  sole clock, rising edge.
REQ-004 SHALL: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL: start  input  1  single-cycle request, sampled only in IDLE.
REQ-006 SHALL: srcBase  input  ADDR_W  address of r[0] in source memory.
REQ-007 SHALL: dstBase  input  ADDR_W  address of r'[0] in destination memory.
REQ-008 SHALL: memReadAddr  output  ADDR_W  source read address.
REQ-009 SHALL: memIn  input  32  read data {r_h[31:16], r_l[15:0]}, valid one cycle after memReadAddr.
REQ-010 SHALL: coefAddr  output  ADDR_W  lag-table index.
REQ-011 SHALL: coefIn  input  32  {lag_h, lag_l}, valid one cycle after coefAddr.
REQ-012 SHALL: memWrite  output  1  write strobe.
REQ-013 SHALL: memWriteAddr  output  ADDR_W  destination address.
REQ-014 SHALL: memOut  output  32  write data {hi, lo}.
REQ-015 SHALL: busy  output  1  high in every state except IDLE.
REQ-016 SHALL: done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL: states IDLE, RD, WT, M1, M2, WR, FIN; IDLE->RD on start; RD->WT->M1->M2->WR; WR->RD if i<ORDER, else WR->FIN; FIN->IDLE.
REQ-018 SHALL: on start, latch srcBase and dstBase and set i=1; base inputs are ignored after that.
REQ-019 SHALL: in RD, drive memReadAddr=srcBase+i and coefAddr=i-1; both addresses wrap modulo 2^ADDR_W.
REQ-020 SHALL: in WT, register memIn and coefIn.
REQ-021 SHALL: compute Mpy_32 with internal saturating arithmetic:
- M1: L = L_mult(r_h, lag_h).
- M2: L = L_mac(L_mac(L, mult(r_h, lag_l), 1), mult(r_l, lag_h), 1).
- All operations use G.729 basic-op saturation.
REQ-022 SHALL: in WR, assert memWrite for exactly one cycle with:
- memWriteAddr = dstBase+i.
- memOut = {hi = L[31:16], lo = (L>>1) - (hi<<15)}.
REQ-023 SHALL: leave r[0] unread and unwritten.
REQ-024 SHALL: assert done in FIN only; latency from the start-sampling edge to done high is 5*ORDER+1 cycles.
REQ-025 SHALL: ignore start while busy, including a start in the FIN cycle.
REQ-026 SHALL: support srcBase==dstBase (in-place); each read precedes its own write.
REQ-027 SHALL: drive memWrite=0 and hold addresses stable in all states other than those above.

Reset
REQ-028 SHALL: on reset low, immediately set state=IDLE, i=0, and all outputs and internal registers to 0.
REQ-029 SHALL: on reset mid-operation, abandon the run without a write or done pulse; coefficients already written stay written.

Configuration
REQ-030 SHALL: with LAG_WINDOW_SAT_FLAG_EN defined:
- Add output satFlag (1 bit), set by any saturation during a run.
- satFlag stays sticky until the next accepted start or reset.
- satFlag is valid at done.
REQ-031 SHALL: without LAG_WINDOW_SAT_FLAG_EN, omit the satFlag port; arithmetic results are identical.

Verification
REQ-032 SHALL: memIn=0x4000_0000, coefIn=0x7FFF_0000 for all i, ORDER=10 -> ten writes of 0x3FFF_4000 at dstBase+1..10, done at cycle 51.
REQ-033 SHALL: memIn=0x8000_0000, coefIn=0x8000_0000 -> memOut=0x7FFF_7FFF; satFlag=1 when the macro is defined.
REQ-034 SHALL: srcBase=0x7FE, dstBase=0x7FE, ORDER=10 -> reads and writes at 0x7FF, 0x000..0x008 (wrap), in-place.
REQ-035 SHALL: start pulsed at cycles 3 and 30 after a first start -> only one run; exactly 10 writes and one done.
REQ-036 SHALL: reset low at cycle 12 of a run -> busy=0, memWrite=0 immediately, no done; a new start runs normally.
REQ-037 SHALL: memIn=0x1234_5678, coefIn=0x7FFF_7FFF -> memOut matches the bit-exact G.729 Mpy_32/L_Extract reference model.
